// File: rtl/stepper_move_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : stepper_move_ctrl
// Brief    : Move controller feeding a 4-phase stepper sequencer; issues N
//            step_clk pulses at a programmable half-period, tracks position.
// Revision : 1.0 - initial release
// ============================================================================
module stepper_move_ctrl #(
    parameter int STEP_W = 12,
    parameter int HALF_W = 16,
    parameter int POS_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              dir_in,
    input  logic [STEP_W-1:0] steps,
    input  logic [HALF_W-1:0] half_period,
    output logic              step_clk,
    output logic              motor_en,
    output logic              motor_dir,
    output logic              busy,
    output logic              done,
    output logic [POS_W-1:0]  position
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_LOW  = 2'd1;
    localparam logic [1:0] c_ST_HIGH = 2'd2;

    localparam logic [HALF_W-1:0] c_HALF_ONE = HALF_W'(1);
    localparam logic [POS_W-1:0]  c_POS_ONE  = POS_W'(1);

    logic [1:0]        r_state;
    logic [HALF_W-1:0] r_half;
    logic [HALF_W-1:0] r_timer;
    logic [STEP_W-1:0] r_remaining;
    logic              r_step_clk;
    logic              r_motor_en;
    logic              r_motor_dir;
    logic              r_busy;
    logic              r_done;
    logic [POS_W-1:0]  r_position;

    // A zero half-period would never expire, so it is promoted to one cycle
    logic [HALF_W-1:0] w_half_eff;
    assign w_half_eff = (half_period == '0) ? c_HALF_ONE : half_period;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_half      <= '0;
            r_timer     <= '0;
            r_remaining <= '0;
            r_step_clk  <= 1'b0;
            r_motor_en  <= 1'b0;
            r_motor_dir <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_position  <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (start && !abort) begin
                        if (steps != '0) begin
                            r_half      <= w_half_eff;
                            r_timer     <= w_half_eff - c_HALF_ONE;
                            r_remaining <= steps;
                            r_motor_dir <= dir_in;
                            r_motor_en  <= 1'b1;
                            r_busy      <= 1'b1;
                            r_step_clk  <= 1'b0;
                            r_state     <= c_ST_LOW;
                        end else begin
                            r_done <= 1'b1;
                        end
                    end
                end
                c_ST_LOW: begin
                    if (abort) begin
                        r_step_clk <= 1'b0;
                        r_motor_en <= 1'b0;
                        r_busy     <= 1'b0;
                        r_state    <= c_ST_IDLE;
                    end else if (r_timer != '0) begin
                        r_timer <= r_timer - c_HALF_ONE;
                    end else begin
                        r_step_clk  <= 1'b1;
                        r_timer     <= r_half - c_HALF_ONE;
                        r_remaining <= r_remaining - STEP_W'(1);
                        r_position  <= r_motor_dir ? (r_position + c_POS_ONE)
                                                   : (r_position - c_POS_ONE);
                        r_state     <= c_ST_HIGH;
                    end
                end
                c_ST_HIGH: begin
                    if (abort) begin
                        r_step_clk <= 1'b0;
                        r_motor_en <= 1'b0;
                        r_busy     <= 1'b0;
                        r_state    <= c_ST_IDLE;
                    end else if (r_timer != '0) begin
                        r_timer <= r_timer - c_HALF_ONE;
                    end else begin
                        r_step_clk <= 1'b0;
                        r_timer    <= r_half - c_HALF_ONE;
                        // remaining was decremented on the rising edge of this step
                        if (r_remaining == '0) begin
                            r_motor_en <= 1'b0;
                            r_busy     <= 1'b0;
                            r_done     <= 1'b1;
                            r_state    <= c_ST_IDLE;
                        end else begin
                            r_state <= c_ST_LOW;
                        end
                    end
                end
                default: begin
                    r_step_clk <= 1'b0;
                    r_motor_en <= 1'b0;
                    r_busy     <= 1'b0;
                    r_state    <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign step_clk  = r_step_clk;
    assign motor_en  = r_motor_en;
    assign motor_dir = r_motor_dir;
    assign busy      = r_busy;
    assign done      = r_done;
    assign position  = r_position;

endmodule
`default_nettype wire

// File: tb/tb_stepper_move_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_stepper_move_ctrl
// Brief    : Self-checking bench: vector table, random moves, reset corner.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stepper_move_ctrl;

    localparam int STEP_W = 12;
    localparam int HALF_W = 16;
    localparam int POS_W  = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic              dir_in = 1'b0;
    logic [STEP_W-1:0] steps = '0;
    logic [HALF_W-1:0] half_period = '0;
    logic              step_clk;
    logic              motor_en;
    logic              motor_dir;
    logic              busy;
    logic              done;
    logic [POS_W-1:0]  position;

    int n_checks = 0;
    int n_errors = 0;

    logic [POS_W-1:0] m_pos = '0;
    logic             m_dir = 1'b0;

    stepper_move_ctrl #(.STEP_W(STEP_W), .HALF_W(HALF_W), .POS_W(POS_W)) u_dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .dir_in(dir_in),
        .steps(steps), .half_period(half_period), .step_clk(step_clk),
        .motor_en(motor_en), .motor_dir(motor_dir), .busy(busy), .done(done),
        .position(position)
    );

    always #5 clk = ~clk;

    typedef struct {
        int   n;
        int   hp;
        bit   d;
        int   a;        // -1: no abort, 0: abort with start, >0: abort at edge E_a
        int   exp_pos;  // absolute position expected after the move
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected outputs after edge E_t follow from the move rules directly:
    // step_clk = floor(t/H) mod 2, steps issued so far = (floor(t/H)+1)/2.
    task automatic run_move(input int n, input int hp, input bit d, input int a, input bit noise);
        int h, end_t, last_t, r;
        bit active;
        logic e_clk, e_busy, e_done, e_dir;
        logic [POS_W-1:0] e_pos;
        h      = (hp == 0) ? 1 : hp;
        active = (n != 0) && (a != 0);
        end_t  = (a > 0) ? a : 2 * n * h;
        last_t = active ? end_t + 1 : 1;
        start = 1'b1; steps = STEP_W'(n); half_period = HALF_W'(hp); dir_in = d;
        abort = (a == 0);
        e_pos = m_pos;
        for (int t = 0; t <= last_t; t++) begin
            @(posedge clk);
            @(negedge clk);
            if (active) begin
                if (t < end_t) begin
                    e_busy = 1'b1; e_clk = 1'((t / h) % 2); e_done = 1'b0;
                    r = (t / h + 1) / 2;
                end else begin
                    e_busy = 1'b0; e_clk = 1'b0; e_done = (a < 0) && (t == end_t);
                    r = (a > 0) ? ((a - 1) / h + 1) / 2 : n;
                end
                e_pos = POS_W'(m_pos + (d ? r : -r));
                e_dir = d;
            end else begin
                e_busy = 1'b0; e_clk = 1'b0; e_pos = m_pos; e_dir = m_dir;
                e_done = (t == 0) && (n == 0) && (a != 0);
            end
            chk("step_clk",  32'(step_clk),  32'(e_clk));
            chk("busy",      32'(busy),      32'(e_busy));
            chk("motor_en",  32'(motor_en),  32'(e_busy));
            chk("done",      32'(done),      32'(e_done));
            chk("motor_dir", 32'(motor_dir), 32'(e_dir));
            chk("position",  32'(position),  32'(e_pos));
            start = 1'b0;
            abort = active && (a > 0) && (t + 1 == a);
            if (noise && active && (t + 1 < end_t)) begin
                start       = 1'($urandom_range(0, 1));
                steps       = STEP_W'($urandom);
                half_period = HALF_W'($urandom);
                dir_in      = 1'($urandom);
            end
        end
        abort = 1'b0;
        m_pos = e_pos;
        if (active) m_dir = d;
    endtask

    initial begin
        vec_t vecs[8];
        int n, hp, a, h;
        bit d;

        vecs[0] = '{3, 2, 1'b1, -1, 3};
        vecs[1] = '{2, 0, 1'b0, -1, 1};
        vecs[2] = '{0, 5, 1'b1, -1, 1};
        vecs[3] = '{5, 3, 1'b1,  9, 2};
        vecs[4] = '{3, 2, 1'b0,  0, 2};
        vecs[5] = '{4, 1, 1'b0, -1, 16'hFFFE};
        vecs[6] = '{2, 1, 1'b1,  1, 16'hFFFE};
        vecs[7] = '{1, 4, 1'b1, -1, 16'hFFFF};

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_step_clk", 32'(step_clk), 32'd0);
        chk("rst_busy",     32'(busy),     32'd0);
        chk("rst_done",     32'(done),     32'd0);
        chk("rst_motor_en", 32'(motor_en), 32'd0);
        chk("rst_position", 32'(position), 32'd0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            run_move(vecs[i].n, vecs[i].hp, vecs[i].d, vecs[i].a, 1'b1);
            chk("table_final_pos", 32'(position), 32'(vecs[i].exp_pos));
        end

        for (int i = 0; i < 40; i++) begin
            n  = $urandom_range(0, 6);
            hp = $urandom_range(0, 4);
            d  = 1'($urandom);
            h  = (hp == 0) ? 1 : hp;
            a  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2 * n * h) : -1;
            run_move(n, hp, d, a, 1'($urandom));
        end

        // Asynchronous reset in the middle of a HIGH phase
        start = 1'b1; steps = STEP_W'(3); half_period = HALF_W'(3); dir_in = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) begin
            @(posedge clk);
            @(negedge clk);
        end
        chk("pre_rst_step_clk", 32'(step_clk), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_step_clk",  32'(step_clk),  32'd0);
        chk("async_motor_en",  32'(motor_en),  32'd0);
        chk("async_busy",      32'(busy),      32'd0);
        chk("async_motor_dir", 32'(motor_dir), 32'd0);
        chk("async_position",  32'(position),  32'd0);
        @(negedge clk);
        rst = 1'b0;
        m_pos = '0;
        m_dir = 1'b0;
        run_move(1, 2, 1'b1, -1, 1'b0);
        chk("post_rst_pos", 32'(position), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
